imem_access_arbiter: RTL
========================

Name: imem_access_arbiter

Overview:
- Shares one single-port synchronous instruction memory between two requesters: the core fetch stage (read) and the boot/program loader (write).
- Arbitrates every cycle and drives the memory command.
- Returns fetch data through a one-entry response buffer with valid/ready backpressure.
- Sits between the fetch stage / loader and the instruction memory array.

Parameters:
- IDX_WIDTH, 10, word-index width; memory depth is 2^IDX_WIDTH 32-bit words.
- MAX_FETCH_STREAK, 4, maximum consecutive fetch grants while a loader request waits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req_valid  in  1  fetch request valid.
- fetch_req_ready  out  1  fetch request accepted this cycle.
- fetch_pc  in  32  byte address of the instruction.
- fetch_rvalid  out  1  fetch response valid.
- fetch_rready  in  1  fetch response consumed.
- fetch_rdata  out  32  instruction word.
- fetch_rerr  out  1  response is an error: misaligned or out-of-range pc.
- load_req_valid  in  1  loader write request valid.
- load_req_ready  out  1  loader write accepted this cycle.
- load_addr  in  32  byte address to write.
- load_wdata  in  32  word to write.
- load_err  out  1  one-cycle pulse: previous accepted write was dropped (bad address).
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  IDX_WIDTH  word index (byte address bits [IDX_WIDTH+1:2]).
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, active-high):
  - response buffer emptied, streak counter 0, load_err 0, in-flight read discarded.
  - while reset is high: all ready/valid outputs, mem_en and mem_we are 0; mem_addr, mem_wdata, fetch_rdata are 0; fetch_rerr is 0.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. Requesters hold address and data stable until accepted.
- Fetch eligibility: the response slot is empty, or its response is consumed this cycle (fetch_rvalid & fetch_rready).
- Arbitration (combinational, each cycle):
  - loader wins if load_req_valid and (streak == MAX_FETCH_STREAK, or fetch not eligible, or fetch_req_valid low).
  - otherwise fetch wins if fetch_req_valid and eligible.
  - at most one ready is high per cycle.
- Streak counter:
  - +1 on each fetch grant while load_req_valid is high, saturating at MAX_FETCH_STREAK.
  - cleared on a loader grant, or in any cycle with load_req_valid low.
- Address check: bad if addr[1:0] != 0 or addr[31:IDX_WIDTH+2] != 0.
- Memory command (combinational from the grant):
  - good fetch grant: mem_en=1, mem_we=0, mem_addr=fetch_pc index.
  - good load grant: mem_en=1, mem_we=1, mem_addr/mem_wdata from the loader.
  - bad grant, or no grant: mem_en=0, mem_we=0.
- Bad loader write: still accepted; no memory write; load_err pulses high the following cycle.
- Bad fetch: accepted; no memory access; next cycle fetch_rvalid=1, fetch_rerr=1, fetch_rdata=0.
- Fetch latency is exactly 1 cycle from acceptance to fetch_rvalid.
- Response path:
  - cycle after a good fetch grant: fetch_rdata = mem_rdata, fetch_rvalid=1.
  - if fetch_rready is low that cycle, mem_rdata is captured into a hold register. fetch_rdata/fetch_rerr then come from the hold register and stay stable until consumed, even if the loader writes the memory meanwhile.
  - fetch_rvalid deasserts the cycle after consumption unless a new fetch was accepted in the consuming cycle (back-to-back: one response per cycle).
- Ordering: a fetch returns the memory content at its grant cycle. A loader write granted later does not alter an in-flight or held response.
- Reset mid-transaction: pending or held responses are dropped; no fetch_rvalid is produced for them after reset.

Test Plan:
- Back-to-back fetches pc=0,4,8,0xC with fetch_rready=1, memory preloaded 0x00000013,0x00100093,0x00200113,0x00308193 → fetch_req_ready high every cycle; fetch_rvalid each following cycle with those words in order; rerr=0.
- Fetch pc=0x4 with fetch_rready low for 3 cycles, loader writes 0xDEADBEEF to 0x4 during the stall → fetch_rdata holds the old word until consumed; fetch_req_ready low while the slot is full; a refetch of 0x4 returns 0xDEADBEEF.
- Continuous fetch_req_valid plus load_req_valid held high, MAX_FETCH_STREAK=4 → exactly 4 fetch grants, then 1 loader grant (mem_we=1), repeating.
- Fetch pc=0x2, and pc=1<<(IDX_WIDTH+2) → mem_en=0; next cycle fetch_rvalid=1, fetch_rerr=1, fetch_rdata=0.
- Loader write to 0x6 → accepted, mem_we stays 0, load_err pulses for one cycle; a following fetch of 0x4 returns the unchanged word.
- Assert reset while a held response is pending, deassert after 2 cycles → all outputs 0 during reset; no stale fetch_rvalid afterwards; the first new fetch completes normally with 1-cycle latency.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
// Shares one single-port synchronous instruction memory between the fetch
// stage (reads) and the program loader (writes). One grant per cycle; fetch
// responses return through a one-entry buffer with valid/ready backpressure.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   fetch_req_valid/ready, fetch_pc fetch request (byte address)
//   fetch_rvalid/rready             fetch response handshake
//   fetch_rdata, fetch_rerr         instruction word / bad-address flag
//   load_req_valid/ready            loader write request
//   load_addr, load_wdata           loader byte address / data
//   load_err                        pulse: previous accepted write was dropped
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            memory command and 1-cycle read data
module imem_access_arbiter #(
  parameter int unsigned IDX_WIDTH        = 10,
  parameter int unsigned MAX_FETCH_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req_valid,
  output logic                 fetch_req_ready,
  input  logic [31:0]          fetch_pc,
  output logic                 fetch_rvalid,
  input  logic                 fetch_rready,
  output logic [31:0]          fetch_rdata,
  output logic                 fetch_rerr,
  input  logic                 load_req_valid,
  output logic                 load_req_ready,
  input  logic [31:0]          load_addr,
  input  logic [31:0]          load_wdata,
  output logic                 load_err,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [IDX_WIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned STREAK_W = (MAX_FETCH_STREAK < 1) ? 1 : $clog2(MAX_FETCH_STREAK + 1);
  localparam int unsigned ADDR_TOP = IDX_WIDTH + 2;

  logic                r_rvalid;     // response slot occupied
  logic                r_rerr;       // slot holds an error response
  logic                r_from_mem;   // slot data is live on mem_rdata (first response cycle)
  logic [31:0]         r_hold_data;  // captured word once the response stalls
  logic [STREAK_W-1:0] r_streak;
  logic                r_load_err;

  logic w_fetch_bad;
  logic w_load_bad;
  logic w_fetch_elig;
  logic w_load_win;
  logic w_fetch_win;
  logic w_consumed;

  // Bad address: misaligned or beyond the memory depth.
  assign w_fetch_bad = (fetch_pc[1:0] != 2'b00) || ((fetch_pc >> ADDR_TOP) != 32'd0);
  assign w_load_bad  = (load_addr[1:0] != 2'b00) || ((load_addr >> ADDR_TOP) != 32'd0);

  assign w_consumed   = r_rvalid && fetch_rready;
  assign w_fetch_elig = !r_rvalid || fetch_rready;

  // Arbitration: loader wins when the fetch streak is exhausted or fetch cannot go.
  always_comb begin
    w_load_win  = 1'b0;
    w_fetch_win = 1'b0;
    if (!reset) begin
      w_load_win  = load_req_valid &&
                    ((r_streak == STREAK_W'(MAX_FETCH_STREAK)) || !w_fetch_elig || !fetch_req_valid);
      w_fetch_win = !w_load_win && fetch_req_valid && w_fetch_elig;
    end
  end

  assign fetch_req_ready = w_fetch_win;
  assign load_req_ready  = w_load_win;

  // Memory command follows the grant; bad addresses never reach the array.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_fetch_win && !w_fetch_bad) begin
      mem_en   = 1'b1;
      mem_addr = fetch_pc[IDX_WIDTH+1:2];
    end else if (w_load_win && !w_load_bad) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = load_addr[IDX_WIDTH+1:2];
      mem_wdata = load_wdata;
    end
  end

  // Response slot, hold register, streak counter and loader error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid    <= 1'b0;
      r_rerr      <= 1'b0;
      r_from_mem  <= 1'b0;
      r_hold_data <= '0;
      r_streak    <= '0;
      r_load_err  <= 1'b0;
    end else begin
      r_load_err <= w_load_win && w_load_bad;

      if (w_fetch_win) begin
        r_rvalid   <= 1'b1;
        r_rerr     <= w_fetch_bad;
        r_from_mem <= !w_fetch_bad;
        if (w_fetch_bad) r_hold_data <= '0;
      end else if (w_consumed) begin
        r_rvalid   <= 1'b0;
        r_rerr     <= 1'b0;
        r_from_mem <= 1'b0;
      end else if (r_rvalid && r_from_mem) begin
        // Stalled: freeze the word so later writes cannot change it.
        r_hold_data <= mem_rdata;
        r_from_mem  <= 1'b0;
      end

      if (!load_req_valid || w_load_win) begin
        r_streak <= '0;
      end else if (w_fetch_win && (r_streak != STREAK_W'(MAX_FETCH_STREAK))) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

  assign fetch_rvalid = r_rvalid;
  assign fetch_rerr   = r_rvalid && r_rerr;
  assign fetch_rdata  = !r_rvalid ? 32'd0 : (r_from_mem ? mem_rdata : r_hold_data);
  assign load_err     = r_load_err;

endmodule
